nibble_serial_sub: RTL and testbench
====================================

Name: nibble_serial_sub

Overview:
- Multi-cycle unsigned subtractor: d = a - b - bi over WIDTH bits, one 4-bit nibble per clock, LSB nibble first.
- Borrow is carried between nibbles in a register.
- Each nibble is computed by a 4-bit lookahead subtract cell.
- Small, low-area arithmetic unit for the lab datapath; driven by a start/busy/done handshake from the controlling FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4; NIB = WIDTH/4 nibble steps.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- bi  in  1  borrow-in, captured on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse; result valid
- d  out  WIDTH  difference a - b - bi mod 2^WIDTH
- bo  out  1  borrow-out; 1 iff a < b + bi (unsigned)
- zero  out  1  d == 0, valid with done and held after

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; busy=0, done=0, d=0, bo=0, zero=0 (zero reset value is 0, not 1).
  - Operand registers and nibble index cleared.
  - Takes effect from any state, including mid-RUN; the in-flight operation is discarded.
- States IDLE, RUN, DONE:
  - IDLE: start=1 -> capture a, b, bi; index k=0; borrow register br=bi; go to RUN.
  - RUN: compute nibble k as a[k] + ~b[k] + ~br via the cell.
    - Write d[4k+3:4k]; br <= borrow of that nibble; k <= k+1.
    - After nibble NIB-1 -> DONE; bo <= final borrow; zero <= (full d == 0).
  - DONE: done=1 for exactly this one cycle.
    - start=1 -> capture new operands, go to RUN (back-to-back); else go to IDLE.
- Timing: start high in cycle 0 -> busy high in cycles 1..NIB -> done high in cycle NIB+1. Latency NIB+1 cycles; throughput one operation per NIB+1 cycles.
- start while busy=1 is ignored; no queueing. Operand inputs need only be stable in the start cycle.
- d, bo, zero are held from DONE through IDLE until the next accepted start.
- During RUN, d nibbles above the current index are unspecified; the bench checks d only when done=1 or later.
- Index counter width: clog2(NIB), minimum 1 bit. For WIDTH=4 there is a single RUN cycle.
- Borrow convention: a nibble borrow is the inverse of the cell carry-out.

Optional Feature:
- Macro: NIBBLE_SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), i.e. two's-complement overflow.
  - Registered at the DONE transition, held like d, reset to 0.
- Undefined: no ovf port, no extra logic; all other behaviour identical.

Decomposition:
- Shared package sub_pkg:
  - constant NIBBLE_W=4
  - state enum {IDLE, RUN, DONE}
  - function nib_count(WIDTH)
- One sub-module, sub4_cla: combinational 4-bit lookahead subtract cell.
  - Inputs x[3:0], y[3:0], bin; outputs diff[3:0], bout.
  - Internally x + ~y + ~bin with generate/propagate lookahead.
  - Instantiated once and reused each RUN cycle.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0234, bi=0, start at cycle 0 -> busy cycles 1-4, done cycle 5, d=0x1000, bo=0, zero=0.
- a=0x0000, b=0x0001, bi=0 -> d=0xFFFF, bo=1, zero=0; borrow ripples through all 4 nibbles.
- a=0x8000, b=0x7FFF, bi=1 -> d=0x0000, bo=0, zero=1; with NIBBLE_SUB_SIGNED_OVF_EN defined, ovf=1.
- start re-asserted in cycle 2 with a=0xFFFF -> ignored, original result returned. start in the done cycle with a=5, b=3 -> next done 5 cycles later, d=0x0002.
- rst high at cycle 3 of an operation -> next cycle busy=0, done=0, d=0, bo=0; no done pulse follows. A fresh start afterwards completes normally.
- Random sweep, 1000 operations with random bi -> d and bo match the (a - b - bi) reference model; done is exactly one cycle per accepted start.

Source files
------------

// File: rtl/nibble_serial_sub_pkg.sv
// sub_pkg: shared constants, FSM state encoding and sizing helper for the
// nibble-serial subtractor.
// Ports: none (package).
package sub_pkg;

  // Width of one serial step; the lookahead cell is built for exactly this.
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of nibble steps needed for an operand of the given width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if: start/busy/done handshake and operand/result bus.
// Ports: master drives start, a, b, bi; slave drives busy, done, d, bo, zero
// (and ovf when NIBBLE_SUB_SIGNED_OVF_EN is defined).
interface nibble_serial_sub_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             zero;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo, zero, ovf
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo, zero, ovf
  );
`else
  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo, zero
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo, zero
  );
`endif

endinterface

// File: rtl/nibble_serial_sub_sub4_cla.sv
// sub4_cla: combinational 4-bit subtract cell, diff = x + ~y + ~bin using
// generate/propagate carry lookahead.
// Ports: x, y (nibbles), bin (borrow in) -> diff (nibble), bout (borrow out).
module sub4_cla (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [3:0] yn;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign yn = ~y;
  assign g  = x & yn;
  assign p  = x ^ yn;

  // A borrow-in of 0 is a carry-in of 1 in the x + ~y form.
  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign diff = p ^ c[3:0];
  // Borrow out is the inverse of the carry out.
  assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle unsigned subtractor d = a - b - bi, one
// nibble per clock LSB first; result after NIB+1 cycles, start ignored while busy.
// Ports: clk, rst (sync, active high); bus.slave carries start/a/b/bi in and
// busy/done/d/bo/zero out, plus ovf when NIBBLE_SUB_SIGNED_OVF_EN is defined.
module nibble_serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_sub_if.slave   bus
);

  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] nib_diff;
  logic                nib_bout;

  // Select the operand nibbles addressed by the step index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (k_q == KW'(n)) begin
        a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Single cell shared by every RUN step; the borrow register closes the loop.
  sub4_cla u_cell (
    .x    (a_nib),
    .y    (b_nib),
    .bin  (br_q),
    .diff (nib_diff),
    .bout (nib_bout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    d_d     = d_q;
    bo_d    = bo_q;
    zero_d  = zero_q;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bi;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (k_q == KW'(n)) begin
            d_d[n*NIBBLE_W +: NIBBLE_W] = nib_diff;
          end
        end
        br_d = nib_bout;
        k_d  = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
          bo_d    = nib_bout;
          // d_d already holds the final nibble here, so this sees the full result.
          zero_d  = (d_d == '0);
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.zero = zero_q;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: directed and random checks of nibble_serial_sub at
// WIDTH=16. Stimulus pushes expected results into a scoreboard queue; a
// monitor pops and compares on every done pulse.
module tb_nibble_serial_sub;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   accepted = 0;
  int   cyc      = 0;
  int   seen     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic z, input logic o);
    exp_t e;
    e.d    = d;
    e.bo   = bo;
    e.zero = z;
    e.ovf  = o;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] t;
    exp_t e;
    t      = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    e.d    = t[15:0];
    e.bo   = t[16];
    e.zero = (t[15:0] == 16'd0);
    e.ovf  = (a[15] != b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  // Present an operation for one cycle, then scramble the operand inputs so a
  // design that reads them after the start cycle produces a wrong result.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi, input exp_t e);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bi    = bi;
    sb.push_back(e);
    accepted++;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bi    = ~bi;
    cyc       = 1;
  endtask

  task automatic wait_done(input string name);
    while (bus.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({name, "_latency"}, cyc, NIB + 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual=done_pulse required=no_pulse");
      end else begin
        mon_e = sb.pop_front();
        chk("d", bus.d, mon_e.d);
        chk("bo", bus.bo, mon_e.bo);
        chk("zero", bus.zero, mon_e.zero);
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
        chk("ovf", bus.ovf, mon_e.ovf);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbi;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bi    = 1'b0;
    tick();
    tick();
    chk("reset_state", {bus.busy, bus.done, bus.d, bus.bo, bus.zero}, '0);
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
    chk("reset_ovf", bus.ovf, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // Basic op with cycle-accurate busy/done timing.
    start_op(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0));
    for (int c = 1; c <= NIB; c++) begin
      chk($sformatf("busy_cycle%0d", c), {bus.busy, bus.done}, 2'b10);
      tick();
    end
    chk("done_cycle5", {bus.busy, bus.done}, 2'b01);
    tick();
    chk("hold1", {bus.done, bus.d, bus.bo, bus.zero}, {1'b0, 16'h1000, 1'b0, 1'b0});
    tick();

    // Borrow ripples through every nibble.
    start_op(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
    wait_done("ripple");
    tick();
    tick();
    chk("hold2", {bus.busy, bus.d, bus.bo}, {1'b0, 16'hFFFF, 1'b1});

    // Zero result with signed overflow.
    start_op(16'h8000, 16'h7FFF, 1'b1, mk(16'h0000, 1'b0, 1'b1, 1'b1));
    wait_done("zero");
    tick();

    // Start during RUN is ignored; start in DONE runs back to back.
    start_op(16'h00F0, 16'h000F, 1'b0, mk(16'h00E1, 1'b0, 1'b0, 1'b0));
    tick();
    cyc       = 2;
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    bus.bi    = 1'b0;
    tick();
    cyc       = 3;
    bus.start = 1'b0;
    wait_done("ignored_start");
    start_op(16'h0005, 16'h0003, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0));
    wait_done("back_to_back");

    // Boundary operands.
    start_op(16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0));
    wait_done("min_minus_max");
    start_op(16'hFFFF, 16'h0000, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
    wait_done("max_minus_zero");
    start_op(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b0, 1'b1));
    wait_done("pos_ovf");
    tick();

    // Reset in cycle 3 of an operation discards it.
    bus.start = 1'b1;
    bus.a     = 16'h4321;
    bus.b     = 16'h1111;
    bus.bi    = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_state", {bus.busy, bus.done, bus.d, bus.bo, bus.zero}, '0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    start_op(16'h0100, 16'h0001, 1'b1, mk(16'h00FE, 1'b0, 1'b0, 1'b0));
    wait_done("after_reset");
    tick();

    // Random sweep, mixing back-to-back and idle-gap starts.
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom_range(0, 1));
      start_op(ra, rb, rbi, model(ra, rb, rbi));
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_per_start", done_cnt, accepted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
